// File: rtl/tt_sweep_pkg.sv
// Shared types and width helpers for the truth-table sweeper.
package tt_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } sweep_state_t;

    // Bits needed to hold values 0..value-1, never less than one bit.
    function automatic int unsigned safe_clog2(input int unsigned value);
        int unsigned width;
        width = 1;
        while ((32'd1 << width) < value) begin
            width++;
        end
        return width;
    endfunction

    // Width of the per-vector hold counter for a given hold length.
    function automatic int unsigned hold_width(input int unsigned hold_cycles);
        return safe_clog2(hold_cycles);
    endfunction

endpackage

// File: rtl/tt_sweep_ctr.sv
// Nested hold/index counter: the hold count runs 0..HOLD_CYCLES-1 per vector,
// the vector index advances on each hold rollover and saturates at the last vector.
module tt_sweep_ctr
    import tt_sweep_pkg::*;
#(
    parameter int N_IN        = 3,
    parameter int HOLD_CYCLES = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear_i,
    input  logic            enable_i,
    output logic [N_IN-1:0] idx_o,
    output logic            last_sample_o,
    output logic            last_vector_o
);

    localparam int              HW        = int'(hold_width(HOLD_CYCLES));
    localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [N_IN-1:0] IDX_LAST  = {N_IN{1'b1}};

    logic [HW-1:0]   hold_q, hold_d;
    logic [N_IN-1:0] idx_q, idx_d;

    // Next-state: clear dominates; index never wraps past the last vector.
    always_comb begin
        hold_d = hold_q;
        idx_d  = idx_q;
        if (clear_i) begin
            hold_d = '0;
            idx_d  = '0;
        end else if (enable_i) begin
            if (hold_q == HOLD_LAST) begin
                hold_d = '0;
                if (idx_q != IDX_LAST) begin
                    idx_d = idx_q + 1'b1;
                end
            end else begin
                hold_d = hold_q + 1'b1;
            end
        end
    end

    // Counter state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
            idx_q  <= '0;
        end else begin
            hold_q <= hold_d;
            idx_q  <= idx_d;
        end
    end

    assign idx_o         = idx_q;
    assign last_sample_o = (hold_q == HOLD_LAST);
    assign last_vector_o = (idx_q == IDX_LAST);

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive stimulus engine: walks every input vector, samples the DUT output
// once per vector and scores it against the EXPECTED truth table.
module truth_table_sweeper
    import tt_sweep_pkg::*;
#(
    parameter int                    N_IN        = 3,
    parameter int                    HOLD_CYCLES = 5,
    parameter logic [(2**N_IN)-1:0]  EXPECTED    = 8'b1110_1000,
    parameter int                    LOOP        = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic            dut_out,
    output logic [N_IN-1:0] dut_in,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   mismatch_cnt,
    output logic [N_IN-1:0] first_fail_idx,
    output logic            first_fail_vld
);

    sweep_state_t    state_q;
    logic [N_IN-1:0] dut_in_q;
    logic            busy_q;
    logic            done_q;
    logic            pass_q;
    logic [N_IN:0]   mismatch_cnt_q;
    logic [N_IN-1:0] first_fail_idx_q;
    logic            first_fail_vld_q;

    logic [N_IN-1:0] ctr_idx;
    logic            ctr_last_sample;
    logic            ctr_last_vector;
    logic            ctr_clear;
    logic            ctr_en;
    logic            start_fire;
    logic            sample_mis;

    // A sweep (re)starts from IDLE on start, or from DONE on start or auto-loop;
    // abort always takes priority.
    always_comb begin
        start_fire = 1'b0;
        if (!abort) begin
            if (state_q == IDLE) begin
                start_fire = start;
            end else if (state_q == DONE) begin
                start_fire = start || (LOOP != 0);
            end
        end
        ctr_clear  = start_fire || abort;
        ctr_en     = (state_q == DRIVE) && !abort;
        sample_mis = (dut_out != EXPECTED[ctr_idx]);
    end

    tt_sweep_ctr #(
        .N_IN        (N_IN),
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_ctr (
        .clk           (clk),
        .rst           (rst),
        .clear_i       (ctr_clear),
        .enable_i      (ctr_en),
        .idx_o         (ctr_idx),
        .last_sample_o (ctr_last_sample),
        .last_vector_o (ctr_last_vector)
    );

    // Sweep FSM with registered stimulus and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            dut_in_q         <= '0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            mismatch_cnt_q   <= '0;
            first_fail_idx_q <= '0;
            first_fail_vld_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort) begin
                // Partial count and first-fail info are deliberately kept.
                state_q  <= IDLE;
                dut_in_q <= '0;
                busy_q   <= 1'b0;
                pass_q   <= 1'b0;
            end else if (start_fire) begin
                state_q          <= DRIVE;
                dut_in_q         <= '0;
                busy_q           <= 1'b1;
                pass_q           <= 1'b0;
                mismatch_cnt_q   <= '0;
                first_fail_vld_q <= 1'b0;
            end else if (state_q == DRIVE && ctr_last_sample) begin
                if (sample_mis) begin
                    mismatch_cnt_q <= mismatch_cnt_q + 1'b1;
                    if (!first_fail_vld_q) begin
                        first_fail_idx_q <= ctr_idx;
                        first_fail_vld_q <= 1'b1;
                    end
                end
                if (!ctr_last_vector) begin
                    dut_in_q <= ctr_idx + 1'b1;
                end else begin
                    state_q  <= DONE;
                    dut_in_q <= '0;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    // Final verdict includes the mismatch scored on this edge.
                    pass_q   <= (mismatch_cnt_q == '0) && !sample_mis;
                end
            end
        end
    end

    assign dut_in         = dut_in_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign mismatch_cnt   = mismatch_cnt_q;
    assign first_fail_idx = first_fail_idx_q;
    assign first_fail_vld = first_fail_vld_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: a single-sweep instance (N_IN=3, H=5) and a
// looping instance (N_IN=2, H=1), each driving a table-lookup model DUT.
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    // Instance 0: N_IN=3, HOLD=5, EXPECTED=E8, LOOP=0
    logic       start0, abort0, dut_out0;
    logic [2:0] dut_in0;
    logic       busy0, done0, pass0;
    logic [3:0] cnt0;
    logic [2:0] ffi0;
    logic       ffv0;
    logic [7:0] tt0;
    // Instance 1: N_IN=2, HOLD=1, EXPECTED=0110, LOOP=1
    logic       start1, abort1, dut_out1;
    logic [1:0] dut_in1;
    logic       busy1, done1, pass1;
    logic [2:0] cnt1;
    logic [1:0] ffi1;
    logic       ffv1;
    logic [3:0] tt1;

    int checks   = 0;
    int failures = 0;

    logic [7:0] ref0;
    logic [3:0] ref1;

    // Model DUTs: plain truth-table lookups chosen per test.
    assign dut_out0 = tt0[dut_in0];
    assign dut_out1 = tt1[dut_in1];

    truth_table_sweeper #(
        .N_IN(3), .HOLD_CYCLES(5), .EXPECTED(8'hE8), .LOOP(0)
    ) dut0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort0), .dut_out(dut_out0),
        .dut_in(dut_in0), .busy(busy0), .done(done0), .pass(pass0),
        .mismatch_cnt(cnt0), .first_fail_idx(ffi0), .first_fail_vld(ffv0)
    );

    truth_table_sweeper #(
        .N_IN(2), .HOLD_CYCLES(1), .EXPECTED(4'b0110), .LOOP(1)
    ) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1), .dut_out(dut_out1),
        .dut_in(dut_in1), .busy(busy1), .done(done1), .pass(pass1),
        .mismatch_cnt(cnt1), .first_fail_idx(ffi1), .first_fail_vld(ffv1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: number of differing vectors among the first nvec.
    function automatic int count_mis(input logic [7:0] tt, input logic [7:0] exp_tt, input int nvec);
        int n = 0;
        for (int k = 0; k < nvec; k++) begin
            if (tt[k] != exp_tt[k]) n++;
        end
        return n;
    endfunction

    // Reference: lowest differing vector among the first nvec, or -1.
    function automatic int first_mis(input logic [7:0] tt, input logic [7:0] exp_tt, input int nvec);
        for (int k = 0; k < nvec; k++) begin
            if (tt[k] != exp_tt[k]) return k;
        end
        return -1;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        start0 = 1'b0; abort0 = 1'b0; start1 = 1'b0; abort1 = 1'b0;
        tt0 = 8'hE8; tt1 = 4'b0110;
        tick(); tick();
        checks++;
        if ({dut_in0, busy0, done0, pass0, cnt0, ffi0, ffv0} !== 14'd0) begin
            failures++;
            $display("FAIL reset0 got=%h required=0", {dut_in0, busy0, done0, pass0, cnt0, ffi0, ffv0});
        end
        checks++;
        if ({dut_in1, busy1, done1, pass1, cnt1, ffi1, ffv1} !== 11'd0) begin
            failures++;
            $display("FAIL reset1 got=%h required=0", {dut_in1, busy1, done1, pass1, cnt1, ffi1, ffv1});
        end
        rst = 1'b0;
        tick();
        $display("reset: outputs checked");
    endtask

    // One full sweep on instance 0; optional mid-sweep start poke (must be ignored).
    task automatic test_sweep(input string name, input logic [7:0] tt, input int poke);
        int n, f;
        n = count_mis(tt, ref0, 8);
        f = first_mis(tt, ref0, 8);
        tt0 = tt;
        start0 = 1'b1;
        tick();                     // now just after E0
        start0 = 1'b0;
        for (int c = 0; c < 40; c++) begin
            checks++;
            if (dut_in0 !== 3'(c / 5) || busy0 !== 1'b1 || done0 !== 1'b0) begin
                failures++;
                $display("FAIL %s_trace c=%0d got dut_in=%0d busy=%b done=%b required dut_in=%0d busy=1 done=0",
                         name, c, dut_in0, busy0, done0, c / 5);
            end
            start0 = (c == poke);
            tick();
        end
        start0 = 1'b0;
        // just after E0+40: done cycle
        checks++;
        if (done0 !== 1'b1 || busy0 !== 1'b0 || dut_in0 !== 3'd0) begin
            failures++;
            $display("FAIL %s_done got done=%b busy=%b dut_in=%0d required done=1 busy=0 dut_in=0",
                     name, done0, busy0, dut_in0);
        end
        checks++;
        if (cnt0 !== 4'(n) || pass0 !== (n == 0) || ffv0 !== (f >= 0)) begin
            failures++;
            $display("FAIL %s_result got cnt=%0d pass=%b ffv=%b required cnt=%0d pass=%b ffv=%b",
                     name, cnt0, pass0, ffv0, n, (n == 0), (f >= 0));
        end
        if (f >= 0) begin
            checks++;
            if (ffi0 !== 3'(f)) begin
                failures++;
                $display("FAIL %s_first got=%0d required=%0d", name, ffi0, f);
            end
        end
        tick();
        checks++;
        if (done0 !== 1'b0 || pass0 !== (n == 0) || cnt0 !== 4'(n) || busy0 !== 1'b0) begin
            failures++;
            $display("FAIL %s_hold got done=%b pass=%b cnt=%0d busy=%b required done=0 pass=%b cnt=%0d busy=0",
                     name, done0, pass0, cnt0, busy0, (n == 0), n);
        end
        $display("sweep %s tt=%h: cnt=%0d first=%0d pass=%b", name, tt, cnt0, ffi0, pass0);
    endtask

    task automatic test_abort(input logic [7:0] tt, input int abort_edge);
        int n, f;
        // Samples at edges strictly before the abort edge are scored.
        n = count_mis(tt, ref0, (abort_edge - 1) / 5);
        f = first_mis(tt, ref0, (abort_edge - 1) / 5);
        tt0 = tt;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int c = 0; c < abort_edge; c++) begin
            abort0 = (c == abort_edge - 1);
            tick();
        end
        abort0 = 1'b0;
        checks++;
        if (busy0 !== 1'b0 || dut_in0 !== 3'd0 || done0 !== 1'b0 || pass0 !== 1'b0) begin
            failures++;
            $display("FAIL abort_state got busy=%b dut_in=%0d done=%b pass=%b required all 0",
                     busy0, dut_in0, done0, pass0);
        end
        checks++;
        if (cnt0 !== 4'(n) || ffv0 !== (f >= 0)) begin
            failures++;
            $display("FAIL abort_partial got cnt=%0d ffv=%b required cnt=%0d ffv=%b", cnt0, ffv0, n, (f >= 0));
        end
        if (f >= 0) begin
            checks++;
            if (ffi0 !== 3'(f)) begin
                failures++;
                $display("FAIL abort_first got=%0d required=%0d", ffi0, f);
            end
        end
        for (int c = 0; c < 45; c++) begin
            tick();
            checks++;
            if (done0 !== 1'b0 || busy0 !== 1'b0) begin
                failures++;
                $display("FAIL abort_idle c=%0d got done=%b busy=%b required 0 0", c, done0, busy0);
            end
        end
        $display("abort at edge %0d tt=%h: cnt=%0d ffv=%b", abort_edge, tt, cnt0, ffv0);
    endtask

    task automatic test_reset_mid();
        tt0 = 8'h80;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int c = 0; c < 11; c++) tick();
        rst = 1'b1;
        start0 = 1'b1;
        tick();
        checks++;
        if ({dut_in0, busy0, done0, pass0, cnt0, ffi0, ffv0} !== 14'd0) begin
            failures++;
            $display("FAIL rst_mid got=%h required=0", {dut_in0, busy0, done0, pass0, cnt0, ffi0, ffv0});
        end
        tick();
        checks++;
        if ({dut_in0, busy0, done0, pass0, cnt0, ffi0, ffv0} !== 14'd0) begin
            failures++;
            $display("FAIL rst_hold got=%h required=0", {dut_in0, busy0, done0, pass0, cnt0, ffi0, ffv0});
        end
        rst = 1'b0;
        start0 = 1'b0;
        tick();
        checks++;
        if (busy0 !== 1'b0 || cnt0 !== 4'd0) begin
            failures++;
            $display("FAIL rst_idle got busy=%b cnt=%0d required 0 0", busy0, cnt0);
        end
        $display("reset mid-sweep: outputs cleared");
    endtask

    // Looping instance: four one-cycle vectors then one DONE cycle, repeating.
    task automatic test_loop(input logic [3:0] tt);
        int n, f, p;
        n = count_mis({4'b0, tt}, {4'b0, ref1}, 4);
        f = first_mis({4'b0, tt}, {4'b0, ref1}, 4);
        tt1 = tt;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int c = 0; c < 20; c++) begin
            p = c % 5;
            checks++;
            if (dut_in1 !== 2'((p < 4) ? p : 0) || busy1 !== (p < 4) || done1 !== (p == 4)) begin
                failures++;
                $display("FAIL loop_trace c=%0d got dut_in=%0d busy=%b done=%b required dut_in=%0d busy=%b done=%b",
                         c, dut_in1, busy1, done1, (p < 4) ? p : 0, (p < 4), (p == 4));
            end
            if (p == 4) begin
                checks++;
                if (pass1 !== (n == 0) || cnt1 !== 3'(n) || ffv1 !== (f >= 0) ||
                    (f >= 0 && ffi1 !== 2'(f))) begin
                    failures++;
                    $display("FAIL loop_result c=%0d got pass=%b cnt=%0d ffv=%b ffi=%0d required pass=%b cnt=%0d first=%0d",
                             c, pass1, cnt1, ffv1, ffi1, (n == 0), n, f);
                end
            end
            tick();
        end
        start1 = 1'b1;
        abort1 = 1'b1;
        tick();
        start1 = 1'b0;
        abort1 = 1'b0;
        checks++;
        if (busy1 !== 1'b0 || dut_in1 !== 2'd0 || pass1 !== 1'b0 || done1 !== 1'b0) begin
            failures++;
            $display("FAIL loop_abort got busy=%b dut_in=%0d pass=%b done=%b required all 0",
                     busy1, dut_in1, pass1, done1);
        end
        for (int c = 0; c < 8; c++) begin
            tick();
            checks++;
            if (busy1 !== 1'b0 || done1 !== 1'b0) begin
                failures++;
                $display("FAIL loop_idle c=%0d got busy=%b done=%b required 0 0", c, busy1, done1);
            end
        end
        $display("loop tt=%b: cnt=%0d pass_expected=%b", tt, n, (n == 0));
    endtask

    initial begin
        ref0 = 8'hE8;
        ref1 = 4'b0110;
        test_reset();
        test_sweep("majority", 8'hE8, -1);
        test_sweep("and3", 8'h80, -1);
        test_sweep("inverted", 8'h17, -1);
        for (int i = 0; i < 4; i++) begin
            test_sweep("random", 8'($urandom), int'($urandom_range(1, 38)));
        end
        test_abort(8'h80, 17);
        test_abort(8'($urandom), int'($urandom_range(1, 39)));
        test_abort(8'($urandom), int'($urandom_range(1, 39)));
        test_sweep("after_abort", 8'hE8, -1);
        test_reset_mid();
        test_loop(4'b0110);
        test_loop(4'($urandom));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
